// File: rtl/sky130_fd_io__lvclamp_trig_ctl.sv
// Trigger controller for the standalone low-voltage ESD clamp: qualifies ramp
// detects, holds the clamp gate on, then locks out re-arming for a while.
module sky130_fd_io__lvclamp_trig_ctl #(
    parameter int DEBOUNCE    = 3,
    parameter int HOLD_CYCLES = 64,
    parameter int LOCKOUT     = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ramp_det,
    input  logic             rail_ok,
    input  logic             force_on,
    output logic             ogc_en,
    output logic             evt_pulse,
    output logic             busy,
    output logic [CNT_W-1:0] event_cnt
);

    localparam int DBW = $clog2(DEBOUNCE + 1);
    localparam int HW  = $clog2(HOLD_CYCLES + 1);
    localparam int LW  = (LOCKOUT > 0) ? $clog2(LOCKOUT + 1) : 1;

    localparam logic [DBW-1:0]   DEB_ONE   = DBW'(1);
    localparam logic [DBW-1:0]   DEB_LAST  = DBW'(DEBOUNCE - 1);
    localparam logic [HW-1:0]    HOLD_ONE  = HW'(1);
    localparam logic [HW-1:0]    HOLD_LOAD = HW'(HOLD_CYCLES);
    localparam logic [LW-1:0]    LOCK_ONE  = LW'(1);
    localparam logic [LW-1:0]    LOCK_LOAD = LW'(LOCKOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        QUAL  = 2'd1,
        CLAMP = 2'd2,
        LOCK  = 2'd3
    } state_t;

    state_t         state, state_nxt;
    logic [DBW-1:0] deb_cnt, deb_nxt;
    logic [HW-1:0]  hold_cnt, hold_nxt;
    logic [LW-1:0]  lock_cnt, lock_nxt;
    logic           fire;

    always_comb begin
        state_nxt = state;
        deb_nxt   = deb_cnt;
        hold_nxt  = hold_cnt;
        lock_nxt  = lock_cnt;
        fire      = 1'b0;
        case (state)
            IDLE: begin
                if (en && ramp_det) begin
                    if (DEBOUNCE == 1) begin
                        state_nxt = CLAMP;
                        fire      = 1'b1;
                    end else begin
                        state_nxt = QUAL;
                        deb_nxt   = DEB_ONE;
                    end
                end
            end
            QUAL: begin
                if (!en || !ramp_det) begin
                    state_nxt = IDLE;
                    deb_nxt   = '0;
                end else if (deb_cnt >= DEB_LAST) begin
                    state_nxt = CLAMP;
                    deb_nxt   = '0;
                    fire      = 1'b1;
                end else begin
                    deb_nxt = deb_cnt + DEB_ONE;
                end
            end
            CLAMP: begin
                // A fresh ramp sample always wins over expiry, even on the expiry edge.
                if (ramp_det) begin
                    hold_nxt = HOLD_LOAD;
                end else if (hold_cnt > HOLD_ONE) begin
                    hold_nxt = hold_cnt - HOLD_ONE;
                end else begin
                    hold_nxt = '0;
                    if (rail_ok) begin
                        if (LOCKOUT == 0) begin
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = LOCK;
                            lock_nxt  = LOCK_LOAD;
                        end
                    end
                end
            end
            LOCK: begin
                if (lock_cnt > LOCK_ONE) begin
                    lock_nxt = lock_cnt - LOCK_ONE;
                end else begin
                    lock_nxt  = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                deb_nxt   = '0;
                hold_nxt  = '0;
                lock_nxt  = '0;
            end
        endcase
        if (fire) begin
            hold_nxt = HOLD_LOAD;
        end
    end

    // Outputs are registered from the next-state decode so they line up with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            deb_cnt   <= '0;
            hold_cnt  <= '0;
            lock_cnt  <= '0;
            ogc_en    <= 1'b0;
            evt_pulse <= 1'b0;
            busy      <= 1'b0;
            event_cnt <= '0;
        end else begin
            state     <= state_nxt;
            deb_cnt   <= deb_nxt;
            hold_cnt  <= hold_nxt;
            lock_cnt  <= lock_nxt;
            ogc_en    <= (state_nxt == CLAMP) | force_on;
            evt_pulse <= fire;
            busy      <= (state_nxt != IDLE);
            if (fire && (event_cnt != '1)) begin
                event_cnt <= event_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_sky130_fd_io__lvclamp_trig_ctl.sv
// Directed bench for the LV clamp trigger controller with DEBOUNCE=3,
// HOLD_CYCLES=8, LOCKOUT=4, CNT_W=2.
module tb_sky130_fd_io__lvclamp_trig_ctl;

    logic       clk;
    logic       rst;
    logic       en;
    logic       ramp_det;
    logic       rail_ok;
    logic       force_on;
    logic       ogc_en;
    logic       evt_pulse;
    logic       busy;
    logic [1:0] event_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    sky130_fd_io__lvclamp_trig_ctl #(
        .DEBOUNCE   (3),
        .HOLD_CYCLES(8),
        .LOCKOUT    (4),
        .CNT_W      (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .ramp_det (ramp_det),
        .rail_ok  (rail_ok),
        .force_on (force_on),
        .ogc_en   (ogc_en),
        .evt_pulse(evt_pulse),
        .busy     (busy),
        .event_cnt(event_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic o, input logic p, input logic b);
        check({tag, ".ogc_en"}, {31'd0, ogc_en}, {31'd0, o});
        check({tag, ".evt_pulse"}, {31'd0, evt_pulse}, {31'd0, p});
        check({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
    endtask

    // Three qualifying samples; returns right after the firing edge.
    task automatic fire3();
        en       = 1'b1;
        ramp_det = 1'b1;
        tick();
        chk_out("fire.q1", 1'b0, 1'b0, 1'b1);
        tick();
        chk_out("fire.q2", 1'b0, 1'b0, 1'b1);
        tick();
        chk_out("fire.entry", 1'b1, 1'b1, 1'b1);
        ramp_det = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] sat_exp [5];
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        // Reset with random inputs, force_on high on the second cycle.
        rst      = 1'b1;
        en       = 1'($urandom_range(0, 1));
        ramp_det = 1'($urandom_range(0, 1));
        rail_ok  = 1'($urandom_range(0, 1));
        force_on = 1'b0;
        tick();
        chk_out("rst1", 1'b0, 1'b0, 1'b0);
        check("rst1.cnt", {30'd0, event_cnt}, 32'd0);
        force_on = 1'b1;
        ramp_det = 1'b1;
        en       = 1'b1;
        tick();
        chk_out("rst2", 1'b0, 1'b0, 1'b0);
        check("rst2.cnt", {30'd0, event_cnt}, 32'd0);
        rst      = 1'b0;
        en       = 1'b0;
        ramp_det = 1'b0;
        rail_ok  = 1'b1;
        tick();
        chk_out("force_idle", 1'b1, 1'b0, 1'b0);
        force_on = 1'b0;
        tick();
        chk_out("idle", 1'b0, 1'b0, 1'b0);

        // Basic fire: high for 8 cycles, busy clears 4 cycles after release.
        fire3();
        check("basic.cnt", {30'd0, event_cnt}, 32'd1);
        for (int i = 3; i <= 9; i++) begin
            tick();
            chk_out("basic.hold", 1'b1, 1'b0, 1'b1);
        end
        tick();
        chk_out("basic.release", 1'b0, 1'b0, 1'b1);
        for (int i = 11; i <= 13; i++) begin
            tick();
            chk_out("basic.lock", 1'b0, 1'b0, 1'b1);
        end
        tick();
        chk_out("basic.idle", 1'b0, 1'b0, 1'b0);
        check("basic.cnt_end", {30'd0, event_cnt}, 32'd1);

        // Glitch: two samples then low.
        en       = 1'b1;
        ramp_det = 1'b1;
        tick();
        chk_out("glitch.q1", 1'b0, 1'b0, 1'b1);
        tick();
        chk_out("glitch.q2", 1'b0, 1'b0, 1'b1);
        ramp_det = 1'b0;
        tick();
        chk_out("glitch.drop", 1'b0, 1'b0, 1'b0);
        check("glitch.cnt", {30'd0, event_cnt}, 32'd1);

        // Disabled: no response.
        en       = 1'b0;
        ramp_det = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("disabled", 1'b0, 1'b0, 1'b0);
        end
        ramp_det = 1'b0;

        // Retrigger at e+4 stretches the window to 12 cycles.
        fire3();
        check("retrig.cnt", {30'd0, event_cnt}, 32'd2);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk_out("retrig.hold_a", 1'b1, 1'b0, 1'b1);
        end
        en       = 1'b0;
        ramp_det = 1'b1;
        tick();
        chk_out("retrig.edge", 1'b1, 1'b0, 1'b1);
        ramp_det = 1'b0;
        for (int i = 5; i <= 11; i++) begin
            tick();
            chk_out("retrig.hold_b", 1'b1, 1'b0, 1'b1);
        end
        tick();
        chk_out("retrig.release", 1'b0, 1'b0, 1'b1);
        check("retrig.cnt_end", {30'd0, event_cnt}, 32'd2);
        for (int i = 13; i <= 15; i++) begin
            tick();
            chk_out("retrig.lock", 1'b0, 1'b0, 1'b1);
        end
        tick();
        chk_out("retrig.idle", 1'b0, 1'b0, 1'b0);

        // rail_ok low at expiry holds the clamp until rail_ok is sampled high.
        fire3();
        check("rail.cnt", {30'd0, event_cnt}, 32'd3);
        rail_ok = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk_out("rail.hold", 1'b1, 1'b0, 1'b1);
        end
        for (int i = 8; i <= 12; i++) begin
            tick();
            chk_out("rail.wait", 1'b1, 1'b0, 1'b1);
        end
        rail_ok = 1'b1;
        tick();
        chk_out("rail.release", 1'b0, 1'b0, 1'b1);

        // Lockout ignores ramp_det; force_on raises ogc_en without extending LOCK.
        ramp_det = 1'b1;
        force_on = 1'b1;
        tick();
        chk_out("lock.force", 1'b1, 1'b0, 1'b1);
        force_on = 1'b0;
        tick();
        chk_out("lock.ign2", 1'b0, 1'b0, 1'b1);
        tick();
        chk_out("lock.ign3", 1'b0, 1'b0, 1'b1);
        tick();
        chk_out("lock.end", 1'b0, 1'b0, 1'b0);
        fire3();
        check("refire.cnt_sat", {30'd0, event_cnt}, 32'd3);
        for (int i = 0; i < 12; i++) tick();
        chk_out("refire.idle", 1'b0, 1'b0, 1'b0);

        // Reset mid-clamp.
        fire3();
        tick();
        tick();
        chk_out("midrst.pre", 1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        chk_out("midrst", 1'b0, 1'b0, 1'b0);
        check("midrst.cnt", {30'd0, event_cnt}, 32'd0);
        rst = 1'b0;
        tick();
        chk_out("midrst.after", 1'b0, 1'b0, 1'b0);

        // Saturation across five events.
        for (int k = 0; k < 5; k++) begin
            fire3();
            check($sformatf("sat.cnt%0d", k), {30'd0, event_cnt}, {30'd0, sat_exp[k]});
            for (int i = 0; i < 12; i++) tick();
            chk_out($sformatf("sat.idle%0d", k), 1'b0, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
